// File: rtl/iob_wishbone2iob_pkg.sv
// Shared definitions for the Wishbone<->IOb bridges: FSM encoding,
// default watchdog width and a request-decode helper.
package iob_wishbone2iob_pkg;

    localparam int IOB_WB_TIMEOUT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } bridge_state_t;

    function automatic logic wb_request(input logic cyc, input logic stb);
        return cyc & stb;
    endfunction

endpackage

// File: rtl/iob_wishbone2iob_if.sv
// Bus bundle between a Wishbone master, the bridge and an IOb slave.
// The slave modport is the bridge's view; master is the environment's view.
interface iob_wishbone2iob_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   wb_addr_i;
    logic [DATA_W/8-1:0] wb_select_i;
    logic                wb_we_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic [DATA_W-1:0]   wb_data_i;
    logic [DATA_W-1:0]   wb_data_o;
    logic                wb_ack_o;
    logic                wb_error_o;
    logic                valid_o;
    logic [ADDR_W-1:0]   address_o;
    logic [DATA_W-1:0]   wdata_o;
    logic [DATA_W/8-1:0] wstrb_o;
    logic [DATA_W-1:0]   rdata_i;
    logic                ready_i;

    modport slave (
        input  wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
        output wb_data_o, wb_ack_o, wb_error_o,
        output valid_o, address_o, wdata_o, wstrb_o,
        input  rdata_i, ready_i
    );

    modport master (
        output wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
        input  wb_data_o, wb_ack_o, wb_error_o,
        input  valid_o, address_o, wdata_o, wstrb_o,
        output rdata_i, ready_i
    );

endinterface

// File: rtl/iob_reg.sv
// Generic register with enable and asynchronous active-high reset to zero.
module iob_reg #(
    parameter int DATA_W = 1
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/iob_wb_watchdog.sv
// Cycle watchdog: clear has priority over enable; tc_o flags the enabled
// cycle in which the counter steps onto all-ones.
module iob_wb_watchdog #(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] CNT_LAST = ~WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires one cycle early so the timeout spans exactly 2**WIDTH-1 REQ cycles.
    assign tc_o = en_i & ~clear_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native master bridge: captures one request,
// holds it on IOb until ready, then returns a one-cycle ack (or error on timeout).
module iob_wishbone2iob
    import iob_wishbone2iob_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = IOB_WB_TIMEOUT_W
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    iob_wishbone2iob_if.slave    bus
);

    localparam int STRB_W = DATA_W / 8;

    bridge_state_t state_q;
    bridge_state_t state_d;

    logic              capture;
    logic              rdata_en;
    logic              wdog_clear;
    logic              wdog_en;
    logic              wdog_tc;

    logic [ADDR_W-1:0] address_d;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_d;
    logic [STRB_W-1:0] wstrb_q;
    logic              is_read_d;
    logic              is_read_q;
    logic [DATA_W-1:0] wb_data_d;
    logic [DATA_W-1:0] wb_data_q;

    assign address_d = bus.wb_addr_i;
    assign wdata_d   = bus.wb_data_i;
    assign wstrb_d   = bus.wb_we_i ? bus.wb_select_i : '0;
    assign is_read_d = ~bus.wb_we_i;
    assign wb_data_d = bus.rdata_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        rdata_en   = 1'b0;
        wdog_clear = 1'b0;
        wdog_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wdog_clear = 1'b1;
                if (wb_request(bus.wb_cyc_i, bus.wb_stb_i)) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                wdog_en = 1'b1;
                // IOb cannot cancel: an abandoned Wishbone cycle still waits for ready.
                if (bus.ready_i) begin
                    rdata_en = is_read_q;
                    state_d  = bus.wb_cyc_i ? ST_ACK : ST_IDLE;
                end else if (wdog_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    iob_reg #(.DATA_W(ADDR_W)) address_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (capture),
        .data_i (address_d),
        .data_o (address_q)
    );

    iob_reg #(.DATA_W(DATA_W)) wdata_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (capture),
        .data_i (wdata_d),
        .data_o (wdata_q)
    );

    iob_reg #(.DATA_W(STRB_W)) wstrb_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (capture),
        .data_i (wstrb_d),
        .data_o (wstrb_q)
    );

    iob_reg #(.DATA_W(1)) is_read_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (capture),
        .data_i (is_read_d),
        .data_o (is_read_q)
    );

    iob_reg #(.DATA_W(DATA_W)) wb_data_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (rdata_en),
        .data_i (wb_data_d),
        .data_o (wb_data_q)
    );

    iob_wb_watchdog #(.WIDTH(TIMEOUT_W)) watchdog (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .clear_i (wdog_clear),
        .en_i    (wdog_en),
        .tc_o    (wdog_tc)
    );

    assign bus.valid_o    = (state_q == ST_REQ);
    assign bus.wb_ack_o   = (state_q == ST_ACK);
    assign bus.wb_error_o = (state_q == ST_ERR);
    assign bus.address_o  = address_q;
    assign bus.wdata_o    = wdata_q;
    assign bus.wstrb_o    = wstrb_q;
    assign bus.wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Directed, table-driven bench for the Wishbone-to-IOb bridge, built with a
// 4-bit watchdog so the timeout path is reachable in a few cycles.
module tb_iob_wishbone2iob;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ready_dly;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_data_o;
        int          exp_ack_cycle;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    vec_t        vecs[6];
    logic [31:0] b2b_addr[4];
    logic [31:0] exp_last_read;

    iob_wishbone2iob_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
        .clk_i  (clk),
        .arst_i (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; the IOb slave answers ready_dly cycles after valid_o first shows.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int   ack_cycle;
        logic hold_ok;
        logic err_seen;
        bus.wb_addr_i   = v.addr;
        bus.wb_select_i = v.sel;
        bus.wb_we_i     = v.we;
        bus.wb_data_i   = v.wdata;
        bus.wb_cyc_i    = 1'b1;
        bus.wb_stb_i    = 1'b1;
        next_cycle();
        check_output($sformatf("v%0d address_o", idx), bus.address_o, v.addr);
        check_output($sformatf("v%0d wstrb_o", idx), {28'b0, bus.wstrb_o}, {28'b0, v.exp_wstrb});
        check_output($sformatf("v%0d wdata_o", idx), bus.wdata_o, v.wdata);
        hold_ok   = 1'b1;
        err_seen  = 1'b0;
        ack_cycle = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.valid_o !== 1'b1 || bus.address_o !== v.addr || bus.wstrb_o !== v.exp_wstrb ||
                bus.wdata_o !== v.wdata || bus.wb_ack_o !== 1'b0)
                hold_ok = 1'b0;
            bus.ready_i = (n == 1 + v.ready_dly);
            bus.rdata_i = v.rdata;
            next_cycle();
            bus.ready_i = 1'b0;
            if (bus.wb_error_o === 1'b1) err_seen = 1'b1;
            if (bus.wb_ack_o === 1'b1) begin
                ack_cycle = n + 1;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        check_output($sformatf("v%0d ack cycle", idx), ack_cycle, v.exp_ack_cycle);
        check_output($sformatf("v%0d wb_data_o", idx), bus.wb_data_o, v.exp_data_o);
        check_output($sformatf("v%0d request held", idx), {31'b0, hold_ok}, 32'd1);
        check_output($sformatf("v%0d no error", idx), {31'b0, err_seen}, 32'd0);
        next_cycle();
        check_output($sformatf("v%0d ack pulse ends", idx), {31'b0, bus.wb_ack_o}, 32'd0);
        check_output($sformatf("v%0d back to idle", idx), {31'b0, bus.valid_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int   nacks;
        int   ack_at[4];
        int   vcnt;
        int   vcount;
        logic advance;
        logic flag;

        vecs[0] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 2,  4'h0, 32'hDEAD_BEEF, 4};
        vecs[1] = '{1'b1, 32'h0000_0204, 4'h3, 32'h1234_5678, 32'hFFFF_0000, 1,  4'h3, 32'hDEAD_BEEF, 3};
        vecs[2] = '{1'b1, 32'h0000_0300, 4'hF, 32'hA5A5_A5A5, 32'h1111_1111, 0,  4'hF, 32'hDEAD_BEEF, 2};
        vecs[3] = '{1'b0, 32'h0000_03FC, 4'h1, 32'h0000_0000, 32'hCAFE_F00D, 0,  4'h0, 32'hCAFE_F00D, 2};
        vecs[4] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'h0000_0000, 5,  4'h0, 32'h0000_0000, 7};
        // ready lands in the 15th REQ cycle, the same cycle the watchdog fires.
        vecs[5] = '{1'b0, 32'h0000_0040, 4'hF, 32'h0000_0000, 32'h0BAD_F00D, 14, 4'h0, 32'h0BAD_F00D, 16};
        b2b_addr[0] = 32'h0000_1000;
        b2b_addr[1] = 32'h0000_1004;
        b2b_addr[2] = 32'h0000_1008;
        b2b_addr[3] = 32'h0000_100C;

        bus.wb_addr_i   = '0;
        bus.wb_select_i = '0;
        bus.wb_we_i     = 1'b0;
        bus.wb_cyc_i    = 1'b0;
        bus.wb_stb_i    = 1'b0;
        bus.wb_data_i   = '0;
        bus.rdata_i     = '0;
        bus.ready_i     = 1'b0;

        repeat (3) next_cycle();
        check_output("reset valid_o", {31'b0, bus.valid_o}, 32'd0);
        check_output("reset ack/err", {30'b0, bus.wb_ack_o, bus.wb_error_o}, 32'd0);
        check_output("reset address_o", bus.address_o, 32'd0);
        check_output("reset wb_data_o", bus.wb_data_o, 32'd0);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], i);
        end
        exp_last_read = 32'h0BAD_F00D;

        // stb alone must never start a transfer.
        bus.wb_stb_i = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            next_cycle();
            if (bus.valid_o !== 1'b0) flag = 1'b1;
        end
        bus.wb_stb_i = 1'b0;
        check_output("stb without cyc ignored", {31'b0, flag}, 32'd0);
        next_cycle();

        // Back-to-back reads; the slave answers in the second valid cycle.
        nacks   = 0;
        vcnt    = 0;
        advance = 1'b0;
        flag    = 1'b0;
        bus.wb_addr_i = b2b_addr[0];
        bus.wb_we_i   = 1'b0;
        bus.wb_select_i = 4'hF;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        for (int c = 0; c < 60 && nacks < 4; c++) begin
            next_cycle();
            if (bus.wb_ack_o === 1'b1 && bus.wb_error_o === 1'b1) flag = 1'b1;
            if (advance) begin
                bus.wb_addr_i = b2b_addr[nacks];
                advance = 1'b0;
            end
            if (bus.wb_ack_o === 1'b1) begin
                check_output($sformatf("b2b data %0d", nacks), bus.wb_data_o, b2b_addr[nacks] ^ 32'h5A5A_0000);
                ack_at[nacks] = c;
                nacks++;
                if (nacks == 4) begin
                    bus.wb_cyc_i = 1'b0;
                    bus.wb_stb_i = 1'b0;
                end else begin
                    advance = 1'b1;
                end
            end
            if (bus.valid_o === 1'b1) vcnt++;
            else vcnt = 0;
            bus.ready_i = (vcnt == 2);
            bus.rdata_i = bus.address_o ^ 32'h5A5A_0000;
        end
        bus.ready_i = 1'b0;
        check_output("b2b ack count", nacks, 32'd4);
        if (nacks == 4) begin
            for (int i = 0; i < 3; i++) begin
                check_output($sformatf("b2b spacing %0d", i), ack_at[i+1] - ack_at[i], 32'd4);
            end
        end
        check_output("b2b ack and error together", {31'b0, flag}, 32'd0);
        exp_last_read = b2b_addr[3] ^ 32'h5A5A_0000;
        next_cycle();

        // Timeout: no ready, 15 REQ cycles then a single error pulse.
        bus.wb_addr_i = 32'h0000_0700;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        next_cycle();
        vcount = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.valid_o !== 1'b1) break;
            vcount++;
            next_cycle();
        end
        check_output("timeout REQ cycles", vcount, 32'd15);
        check_output("timeout error pulse", {31'b0, bus.wb_error_o}, 32'd1);
        check_output("timeout no ack", {31'b0, bus.wb_ack_o}, 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        next_cycle();
        check_output("timeout error one cycle", {31'b0, bus.wb_error_o}, 32'd0);
        next_cycle();
        next_cycle();
        bus.ready_i = 1'b1;
        bus.rdata_i = 32'h9999_9999;
        flag = 1'b0;
        repeat (4) begin
            next_cycle();
            bus.ready_i = 1'b0;
            if (bus.wb_ack_o !== 1'b0 || bus.wb_error_o !== 1'b0 || bus.valid_o !== 1'b0) flag = 1'b1;
        end
        check_output("late ready ignored", {31'b0, flag}, 32'd0);
        check_output("timeout keeps wb_data_o", bus.wb_data_o, exp_last_read);

        // Abort: cyc dropped one cycle into REQ, slave answers at cycle 5.
        bus.wb_addr_i = 32'h0000_0500;
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        next_cycle();
        check_output("abort valid at cycle 1", {31'b0, bus.valid_o}, 32'd1);
        next_cycle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        flag = 1'b0;
        for (int n = 2; n <= 5; n++) begin
            if (bus.valid_o !== 1'b1) flag = 1'b1;
            bus.ready_i = (n == 5);
            bus.rdata_i = 32'h7777_7777;
            next_cycle();
        end
        bus.ready_i = 1'b0;
        check_output("abort valid held", {31'b0, flag}, 32'd0);
        flag = 1'b0;
        repeat (4) begin
            if (bus.wb_ack_o !== 1'b0 || bus.wb_error_o !== 1'b0 || bus.valid_o !== 1'b0) flag = 1'b1;
            next_cycle();
        end
        check_output("abort no response", {31'b0, flag}, 32'd0);

        // Asynchronous reset while a write is outstanding.
        bus.wb_addr_i   = 32'h0000_0600;
        bus.wb_we_i     = 1'b1;
        bus.wb_select_i = 4'hC;
        bus.wb_data_i   = 32'hFEED_FACE;
        bus.wb_cyc_i    = 1'b1;
        bus.wb_stb_i    = 1'b1;
        next_cycle();
        check_output("pre-reset valid", {31'b0, bus.valid_o}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check_output("async reset valid_o", {31'b0, bus.valid_o}, 32'd0);
        check_output("async reset address_o", bus.address_o, 32'd0);
        check_output("async reset wdata_o", bus.wdata_o, 32'd0);
        check_output("async reset wstrb_o", {28'b0, bus.wstrb_o}, 32'd0);
        check_output("async reset wb_data_o", bus.wb_data_o, 32'd0);
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        next_cycle();
        bus.ready_i = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            next_cycle();
            bus.ready_i = 1'b0;
            if (bus.wb_ack_o !== 1'b0 || bus.valid_o !== 1'b0) flag = 1'b1;
        end
        check_output("stray ready after reset", {31'b0, flag}, 32'd0);

        apply_stimulus('{1'b0, 32'h0000_0800, 4'hF, 32'h0000_0000, 32'h600D_CAFE, 1, 4'h0, 32'h600D_CAFE, 3}, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
